// File: rtl/spad_pkg.sv
// Shared scratchpad definitions: operation and bank codes, sequencer states.
package spad_pkg;

  typedef enum logic [1:0] {
    SPAD_RD   = 2'b00,
    SPAD_WR   = 2'b01,
    SPAD_SWAP = 2'b10,
    SPAD_RSVD = 2'b11
  } spad_op_e;

  typedef enum logic [1:0] {
    SPAD_TMP = 2'b00,
    SPAD_GPR = 2'b01,
    SPAD_IPR = 2'b10,
    SPAD_BAD = 2'b11
  } spad_bank_e;

  typedef enum logic [2:0] {
    StIdle,
    StRsetup,
    StRsample,
    StWsetup,
    StWpulse,
    StWhold,
    StDone
  } spad_state_e;

endpackage

// File: rtl/spad_seq_if.sv
// Request handshake plus scratchpad array bus for the access sequencer.
interface spad_seq_if;

  logic        req_h;
  logic [1:0]  op_h;
  logic [1:0]  bank_h;
  logic [3:0]  addr_h;
  logic [3:0]  bmask_h;
  logic [31:0] wdata_h;
  logic        ack_h;
  logic        err_h;
  logic [31:0] rdata_h;

  logic [3:0]  rspa_h;
  logic [31:0] wbus_h;
  logic [3:0]  spw_l;
  logic        rcs_tmp_l;
  logic        rcs_gpr_l;
  logic        rcs_ipr_l;
  logic [31:0] rbus_l;

  // Requester (microcode control) view.
  modport master (
    output req_h, op_h, bank_h, addr_h, bmask_h, wdata_h,
    input  ack_h, err_h, rdata_h
  );

  // Sequencer view: serves requests, drives the array.
  modport slave (
    input  req_h, op_h, bank_h, addr_h, bmask_h, wdata_h, rbus_l,
    output ack_h, err_h, rdata_h, rspa_h, wbus_h, spw_l,
    output rcs_tmp_l, rcs_gpr_l, rcs_ipr_l
  );

  // Scratchpad array view.
  modport array (
    input  rspa_h, wbus_h, spw_l, rcs_tmp_l, rcs_gpr_l, rcs_ipr_l,
    output rbus_l
  );

endinterface

// File: rtl/spad_bank_dec.sv
// Bank code to active-low chip select decode; illegal bank selects nothing.
module spad_bank_dec
  import spad_pkg::*;
(
  input  logic       en_i,
  input  logic [1:0] bank_i,
  output logic       cs_tmp_l_o,
  output logic       cs_gpr_l_o,
  output logic       cs_ipr_l_o
);

  // At most one select is driven low, and only when enabled.
  always_comb begin
    cs_tmp_l_o = 1'b1;
    cs_gpr_l_o = 1'b1;
    cs_ipr_l_o = 1'b1;
    if (en_i) begin
      case (bank_i)
        SPAD_TMP: cs_tmp_l_o = 1'b0;
        SPAD_GPR: cs_gpr_l_o = 1'b0;
        SPAD_IPR: cs_ipr_l_o = 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/spad_seq.sv
// Scratchpad access sequencer: single-word read/write/swap with bracketed
// write strobes. Every array-side output comes straight from a flop.
module spad_seq
  import spad_pkg::*;
(
  input  logic     clk_h,
  input  logic     reset_l,
  spad_seq_if.slave bus
);

  spad_state_e state_q;
  spad_op_e    op_q;
  logic [1:0]  bank_q;
  logic [3:0]  bmask_q;
  logic [31:0] wdata_q;

  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [3:0]  rspa_q;
  logic [31:0] wbus_q;
  logic [3:0]  spw_q;
  logic [2:0]  rcs_q;  // {tmp, gpr, ipr}

  logic        req_legal;
  logic        dec_en;
  logic [1:0]  dec_bank;
  logic        cs_tmp_l;
  logic        cs_gpr_l;
  logic        cs_ipr_l;

  assign req_legal = (bus.bank_h != SPAD_BAD) && (bus.op_h != SPAD_RSVD);

  // Chip-select enable for the state being entered, so CS is registered.
  always_comb begin
    dec_en   = 1'b0;
    dec_bank = bank_q;
    unique case (state_q)
      StIdle: begin
        dec_en   = bus.req_h & req_legal;
        dec_bank = bus.bank_h;
      end
      StRsetup, StWsetup, StWpulse: dec_en = 1'b1;
      StRsample:                    dec_en = (op_q == SPAD_SWAP);
      default:                      dec_en = 1'b0;
    endcase
  end

  spad_bank_dec u_bank_dec (
    .en_i       (dec_en),
    .bank_i     (dec_bank),
    .cs_tmp_l_o (cs_tmp_l),
    .cs_gpr_l_o (cs_gpr_l),
    .cs_ipr_l_o (cs_ipr_l)
  );

  // Sequencer FSM with registered outputs; reset aborts any strobe at once.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      op_q    <= SPAD_RD;
      bank_q  <= 2'b00;
      bmask_q <= 4'h0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      rspa_q  <= 4'h0;
      wbus_q  <= 32'h0;
      spw_q   <= 4'hF;
      rcs_q   <= 3'b111;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      spw_q <= 4'hF;
      rcs_q <= {cs_tmp_l, cs_gpr_l, cs_ipr_l};
      unique case (state_q)
        StIdle: begin
          if (bus.req_h) begin
            op_q    <= spad_op_e'(bus.op_h);
            bank_q  <= bus.bank_h;
            bmask_q <= bus.bmask_h;
            wdata_q <= bus.wdata_h;
            if (!req_legal) begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              rspa_q <= bus.addr_h;
              if (bus.op_h == SPAD_WR) begin
                wbus_q  <= bus.wdata_h;
                state_q <= StWsetup;
              end else begin
                state_q <= StRsetup;
              end
            end
          end
        end
        StRsetup: state_q <= StRsample;
        StRsample: begin
          rdata_q <= ~bus.rbus_l;
          if (op_q == SPAD_SWAP) begin
            wbus_q  <= wdata_q;
            state_q <= StWsetup;
          end else begin
            ack_q   <= 1'b1;
            state_q <= StDone;
          end
        end
        StWsetup: begin
          spw_q   <= ~bmask_q;
          state_q <= StWpulse;
        end
        StWpulse: state_q <= StWhold;
        StWhold: begin
          ack_q   <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack_h     = ack_q;
  assign bus.err_h     = err_q;
  assign bus.rdata_h   = rdata_q;
  assign bus.rspa_h    = rspa_q;
  assign bus.wbus_h    = wbus_q;
  assign bus.spw_l     = spw_q;
  assign bus.rcs_tmp_l = rcs_q[2];
  assign bus.rcs_gpr_l = rcs_q[1];
  assign bus.rcs_ipr_l = rcs_q[0];

endmodule
